io_ctrl_seq: RTL and testbench
==============================

// Module: io_ctrl_seq
// PURPOSE
//  Parametrised successor to the board I/O controller; sits on the SPI register bus beside the modem blocks.
//  Drives LEDs, PMOD pins and a generic NUM_RF_PINS RF front-end switch vector.
//  The RF pattern comes from a programmable mode table, or from a raw debug register.
//  Every RF pattern change uses a break-before-make sequence: safe state, guard time, new pattern, settle time.
//  Also debounces the user button and latches press events.
// PARAMETERS
//  NUM_RF_PINS      8         RF control outputs, 1..8
//  PMOD_WIDTH       4         PMOD pins, 1..8
//  SAFE_PATTERN     8'h56     RF pattern for reset/guard (LNAs shut, mixer off); low NUM_RF_PINS bits used
//  GUARD_CYCLES     16        clocks in safe state before a new pattern, >=1
//  SETTLE_CYCLES    64        clocks after a new pattern before busy drops, >=1
//  DEBOUNCE_CYCLES  1024      consecutive stable samples to accept a button level, >=2
// PORTS
//  i_sys_clk      in   1            system clock
//  i_rst_b        in   1            asynchronous active-low reset
//  i_ioc          in   5            register address
//  i_data_in      in   8            write data
//  o_data_out     out  8            read data, registered
//  i_cs           in   1            block select
//  i_fetch_cmd    in   1            read strobe, 1 clk
//  i_load_cmd     in   1            write strobe, 1 clk
//  i_button       in   1            raw button, asynchronous
//  i_config       in   4            config straps
//  o_led0,o_led1  out  1            LEDs
//  o_pmod         out  PMOD_WIDTH   PMOD values
//  o_pmod_dir     out  PMOD_WIDTH   PMOD direction, 1 = output
//  o_rf_pins      out  NUM_RF_PINS  RF switch/LNA/mixer controls
//  o_rf_busy      out  1            sequencer not idle
//  o_btn_irq      out  1            sticky button-press flag
// BEHAVIOUR
//  Bus
//   - Acts only when i_cs=1. Fetch and load in the same clock: fetch wins, no write.
//   - o_data_out updates 1 clk after fetch and holds otherwise. Unmapped reads return 8'h00; unmapped writes are ignored.
//  Register map
//   - 00000 version (RO)     = 8'h02
//   - 00001 mode             [1:0] dbg (00 table, 01 debug, others = table); [4:2] rf_mode; read [7] = o_rf_busy
//   - 00010 dig              [0] led0, [1] led1 (RW); read [6:3] = i_config, [7] = debounced button
//   - 00011 pmod_dir         low PMOD_WIDTH bits
//   - 00100 pmod_val         low PMOD_WIDTH bits
//   - 00101 rf_dbg           write = debug pattern; read = current o_rf_pins, zero-extended
//   - 00110 tbl_addr         [2:0]
//   - 00111 tbl_data         table[tbl_addr] RW; tbl_addr does not auto-increment
//   - 01000 status (RO)      [0] busy, [1] btn_irq; a read clears btn_irq the next clk unless a new press lands on that same clk
//  Reset values
//   - o_data_out, LEDs, pmod, pmod_dir, dbg, rf_mode, tbl_addr, rf_dbg: 0
//   - All 8 table entries: SAFE_PATTERN; o_rf_pins: SAFE_PATTERN
//   - o_rf_busy, o_btn_irq: 0; FSM: IDLE; debounced button: 0
//  Sequencer
//   - target = (dbg==01) ? rf_dbg : table[rf_mode], evaluated every clk.
//   - IDLE: if target != o_rf_pins, next clk: o_rf_pins <= SAFE_PATTERN, cnt <= GUARD_CYCLES-1, go GUARD.
//   - GUARD: decrement cnt; at cnt==0: o_rf_pins <= target (sampled now), cnt <= SETTLE_CYCLES-1, go SETTLE.
//     Target changes during GUARD are absorbed; the guard does not restart.
//   - SETTLE: if target != o_rf_pins, return to GUARD (safe pattern, cnt reload); else at cnt==0 go IDLE.
//   - o_rf_busy = (state != IDLE), registered with state.
//   - Worst-case latency from write to pattern applied: 1 + GUARD_CYCLES clks.
//   - A table write to an entry that is not selected causes no transition.
//   - Reset mid-sequence: outputs return to SAFE_PATTERN at once, FSM IDLE.
//  Button
//   - 2-FF synchroniser, then counter. Accept the new level after DEBOUNCE_CYCLES consecutive samples differing from the current level.
//   - Any mismatch-free sample resets the counter. Accepted 0->1 sets btn_irq.
// TESTING
//  - Reset: o_rf_pins=SAFE, busy=0, read 00000 -> 8'h02, read 00111 (addr 0) -> SAFE.
//  - tbl[2]=8'hA5, write mode=8'h08 -> 1 clk later pins=SAFE, busy=1; after 16 clks pins=A5; 64 clks later busy=0.
//  - In SETTLE, write mode=8'h0C (tbl[3]=8'h3C) -> pins back to SAFE, after 16 clks pins=3C.
//  - dbg=01, rf_dbg=8'hFF -> pins FF after guard; read 00101 -> FF; dbg=00 -> returns to table pattern via guard.
//  - Button glitch of 500 clks -> no change; 1100-clk press -> read 00010 [7]=1, status=8'h02, second status read=8'h00.
//  - Fetch+load same clk on 00010 with data 8'h03 -> LEDs unchanged, o_data_out = current value.

Source files
------------

// File: rtl/io_ctrl_seq.sv
// Board I/O controller: register bus, LEDs/PMOD, break-before-make RF sequencer, button debounce.
// Latency: register read data 1 clk after fetch; RF pattern applied 1+GUARD_CYCLES clks after target change.
// Backpressure: none; bus strobes are single-cycle and always accepted, fetch wins over load.
module io_ctrl_seq #(
  parameter int          NUM_RF_PINS     = 8,
  parameter int          PMOD_WIDTH      = 4,
  parameter logic [7:0]  SAFE_PATTERN    = 8'h56,
  parameter int          GUARD_CYCLES    = 16,
  parameter int          SETTLE_CYCLES   = 64,
  parameter int          DEBOUNCE_CYCLES = 1024
) (
  input  logic                   i_sys_clk,
  input  logic                   i_rst_b,
  input  logic [4:0]             i_ioc,
  input  logic [7:0]             i_data_in,
  output logic [7:0]             o_data_out,
  input  logic                   i_cs,
  input  logic                   i_fetch_cmd,
  input  logic                   i_load_cmd,
  input  logic                   i_button,
  input  logic [3:0]             i_config,
  output logic                   o_led0,
  output logic                   o_led1,
  output logic [PMOD_WIDTH-1:0]  o_pmod,
  output logic [PMOD_WIDTH-1:0]  o_pmod_dir,
  output logic [NUM_RF_PINS-1:0] o_rf_pins,
  output logic                   o_rf_busy,
  output logic                   o_btn_irq
);

  localparam int CNT_MAX = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CW-1:0]          GUARD_LD  = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0]          SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0]          DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_RF_PINS-1:0] SAFE_RF   = SAFE_PATTERN[NUM_RF_PINS-1:0];

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_SETTLE} state_t;

  // Register file state
  logic [1:0]            dbg_q;
  logic [2:0]            rf_mode_q;
  logic                  led0_q, led1_q;
  logic [PMOD_WIDTH-1:0] pmod_dir_q, pmod_val_q;
  logic [7:0]            rf_dbg_q;
  logic [2:0]            tbl_addr_q;
  logic [7:0]            tbl_q [8];
  logic [7:0]            data_out_q;
  logic [7:0]            rd_dat;

  // Sequencer state
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_RF_PINS-1:0] pins_q, pins_d;
  logic                  busy_q;
  logic [NUM_RF_PINS-1:0] target;
  logic                  tgt_diff;

  // Button state
  logic                  btn_s1_q, btn_s2_q, btn_db_q;
  logic [DW-1:0]         db_cnt_q;
  logic                  btn_accept, btn_press;
  logic                  irq_q, irq_d;

  // Bus decode: a simultaneous fetch suppresses the load
  logic bus_rd, bus_wr, status_rd;
  assign bus_rd    = i_cs & i_fetch_cmd;
  assign bus_wr    = i_cs & i_load_cmd & ~i_fetch_cmd;
  assign status_rd = bus_rd & (i_ioc == 5'h08);

  // Read mux for the addressed register
  always_comb begin
    rd_dat = 8'h00;
    case (i_ioc)
      5'h00: rd_dat = 8'h02;
      5'h01: rd_dat = {busy_q, 2'b00, rf_mode_q, dbg_q};
      5'h02: rd_dat = {btn_db_q, i_config, 1'b0, led1_q, led0_q};
      5'h03: rd_dat[PMOD_WIDTH-1:0] = pmod_dir_q;
      5'h04: rd_dat[PMOD_WIDTH-1:0] = pmod_val_q;
      5'h05: rd_dat[NUM_RF_PINS-1:0] = pins_q;
      5'h06: rd_dat = {5'b00000, tbl_addr_q};
      5'h07: rd_dat = tbl_q[tbl_addr_q];
      5'h08: rd_dat = {6'b000000, irq_q, busy_q};
      default: rd_dat = 8'h00;
    endcase
  end

  // Read data register: captures on fetch, holds otherwise
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) data_out_q <= 8'h00;
    else if (bus_rd) data_out_q <= rd_dat;
  end

  // Control register writes
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      dbg_q      <= 2'b00;
      rf_mode_q  <= 3'd0;
      led0_q     <= 1'b0;
      led1_q     <= 1'b0;
      pmod_dir_q <= '0;
      pmod_val_q <= '0;
      rf_dbg_q   <= 8'h00;
      tbl_addr_q <= 3'd0;
    end else if (bus_wr) begin
      case (i_ioc)
        5'h01: begin
          dbg_q     <= i_data_in[1:0];
          rf_mode_q <= i_data_in[4:2];
        end
        5'h02: begin
          led0_q <= i_data_in[0];
          led1_q <= i_data_in[1];
        end
        5'h03: pmod_dir_q <= i_data_in[PMOD_WIDTH-1:0];
        5'h04: pmod_val_q <= i_data_in[PMOD_WIDTH-1:0];
        5'h05: rf_dbg_q   <= i_data_in;
        5'h06: tbl_addr_q <= i_data_in[2:0];
        default: ;
      endcase
    end
  end

  // Mode table: all entries start at the safe pattern
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      for (int i = 0; i < 8; i++) tbl_q[i] <= SAFE_PATTERN;
    end else if (bus_wr && (i_ioc == 5'h07)) begin
      tbl_q[tbl_addr_q] <= i_data_in;
    end
  end

  // Desired pattern: raw debug value only for dbg==01, table otherwise
  assign target   = (dbg_q == 2'b01) ? rf_dbg_q[NUM_RF_PINS-1:0]
                                     : tbl_q[rf_mode_q][NUM_RF_PINS-1:0];
  assign tgt_diff = (target != pins_q);

  // Sequencer state, pin and counter registers
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pins_q  <= SAFE_RF;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pins_q  <= pins_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Sequencer next state; the guard is never restarted by a change during GUARD
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tgt_diff) state_d = S_GUARD;
      S_GUARD:  if (cnt_q == '0) state_d = S_SETTLE;
      S_SETTLE: begin
        if (tgt_diff)          state_d = S_GUARD;
        else if (cnt_q == '0)  state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Sequencer outputs: safe pattern on entry to guard, target at guard expiry
  always_comb begin
    pins_d = pins_q;
    cnt_d  = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (tgt_diff) begin
          pins_d = SAFE_RF;
          cnt_d  = GUARD_LD;
        end
      end
      S_GUARD: begin
        if (cnt_q == '0) begin
          pins_d = target;
          cnt_d  = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SETTLE: begin
        if (tgt_diff) begin
          pins_d = SAFE_RF;
          cnt_d  = GUARD_LD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        pins_d = SAFE_RF;
        cnt_d  = '0;
      end
    endcase
  end

  // Button: accept a new level on the DEBOUNCE_CYCLES-th consecutive differing sample
  assign btn_accept = (btn_s2_q != btn_db_q) && (db_cnt_q == DB_LAST);
  assign btn_press  = btn_accept && btn_s2_q;

  // Synchroniser and debounce counter
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      btn_s1_q <= i_button;
      btn_s2_q <= btn_s1_q;
      if (btn_s2_q == btn_db_q) begin
        db_cnt_q <= '0;
      end else if (btn_accept) begin
        btn_db_q <= btn_s2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  // Sticky press flag: a new press beats a status-read clear on the same clk
  always_comb begin
    irq_d = irq_q;
    if (btn_press)      irq_d = 1'b1;
    else if (status_rd) irq_d = 1'b0;
  end

  // Press flag register
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign o_data_out = data_out_q;
  assign o_led0     = led0_q;
  assign o_led1     = led1_q;
  assign o_pmod     = pmod_val_q;
  assign o_pmod_dir = pmod_dir_q;
  assign o_rf_pins  = pins_q;
  assign o_rf_busy  = busy_q;
  assign o_btn_irq  = irq_q;

endmodule

// File: tb/tb_io_ctrl_seq.sv
// Bench for io_ctrl_seq: register-map model with read scoreboard, RF sequencing timing, debounce.
// Read responses are queued at issue time and checked by an independent monitor.
// Inputs are driven 1 time unit after the rising edge; outputs sampled on the falling edge or #1.
module tb_io_ctrl_seq;

  localparam logic [7:0] SAFE = 8'h56;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic [4:0] ioc = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       cs = 1'b0, fetch = 1'b0, load = 1'b0;
  logic       button = 1'b0;
  logic [3:0] cfg;
  logic       led0, led1;
  logic [3:0] pmod, pmod_dir;
  logic [7:0] rf_pins;
  logic       rf_busy, btn_irq;

  always #5 clk = ~clk;

  io_ctrl_seq dut (
    .i_sys_clk(clk), .i_rst_b(rst_b), .i_ioc(ioc), .i_data_in(din), .o_data_out(dout),
    .i_cs(cs), .i_fetch_cmd(fetch), .i_load_cmd(load), .i_button(button), .i_config(cfg),
    .o_led0(led0), .o_led1(led1), .o_pmod(pmod), .o_pmod_dir(pmod_dir),
    .o_rf_pins(rf_pins), .o_rf_busy(rf_busy), .o_btn_irq(btn_irq)
  );

  int checks = 0;
  int failures = 0;

  typedef struct { logic [4:0] a; logic [7:0] e; } rd_t;
  rd_t expq[$];

  // Reference register map
  logic [7:0] m_tbl [8];
  logic [1:0] m_dbg;
  logic [2:0] m_mode, m_taddr;
  logic       m_led0, m_led1, m_busy, m_irq, m_btn;
  logic [3:0] m_pdir, m_pval;
  logic [7:0] m_rfdbg, m_pins;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_tbl[i] = SAFE;
    m_dbg = 0; m_mode = 0; m_taddr = 0; m_led0 = 0; m_led1 = 0;
    m_pdir = 0; m_pval = 0; m_rfdbg = 0; m_pins = SAFE; m_busy = 0; m_irq = 0; m_btn = 0;
  endtask

  function automatic logic [7:0] exp_read(input logic [4:0] a);
    case (a)
      5'h00: return 8'h02;
      5'h01: return {m_busy, 2'b00, m_mode, m_dbg};
      5'h02: return {m_btn, cfg, 1'b0, m_led1, m_led0};
      5'h03: return {4'h0, m_pdir};
      5'h04: return {4'h0, m_pval};
      5'h05: return m_pins;
      5'h06: return {5'b0, m_taddr};
      5'h07: return m_tbl[m_taddr];
      5'h08: return {6'b0, m_irq, m_busy};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [7:0] d);
    case (a)
      5'h01: begin m_dbg = d[1:0]; m_mode = d[4:2]; end
      5'h02: begin m_led0 = d[0]; m_led1 = d[1]; end
      5'h03: m_pdir = d[3:0];
      5'h04: m_pval = d[3:0];
      5'h05: m_rfdbg = d;
      5'h06: m_taddr = d[2:0];
      5'h07: m_tbl[m_taddr] = d;
      default: ;
    endcase
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [7:0] d, input logic sel = 1'b1);
    @(posedge clk); #1;
    cs = sel; ioc = a; din = d; load = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; load = 1'b0;
    if (sel) model_write(a, d);
  endtask

  task automatic bus_read(input logic [4:0] a);
    rd_t r;
    @(posedge clk); #1;
    cs = 1'b1; ioc = a; fetch = 1'b1;
    r.a = a; r.e = exp_read(a);
    expq.push_back(r);
    @(posedge clk); #1;
    cs = 1'b0; fetch = 1'b0;
    if (a == 5'h08) m_irq = 1'b0;
  endtask

  task automatic bus_both(input logic [4:0] a, input logic [7:0] d);
    rd_t r;
    @(posedge clk); #1;
    cs = 1'b1; ioc = a; din = d; fetch = 1'b1; load = 1'b1;
    r.a = a; r.e = exp_read(a);
    expq.push_back(r);
    @(posedge clk); #1;
    cs = 1'b0; fetch = 1'b0; load = 1'b0;
  endtask

  // Called right after the write that changes the target has been sampled
  task automatic expect_seq(input string nm, input logic [7:0] pat);
    @(posedge clk); #1;
    chk({nm, "_safe"}, rf_pins, SAFE);
    chk({nm, "_busy"}, rf_busy, 1'b1);
    repeat (15) @(posedge clk);
    #1 chk({nm, "_guard_end"}, rf_pins, SAFE);
    @(posedge clk); #1;
    chk({nm, "_applied"}, rf_pins, pat);
    m_pins = pat;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (rf_busy && n < 300) begin @(posedge clk); #1; n++; end
    chk({nm, "_idle"}, rf_busy, 1'b0);
  endtask

  // Monitor: compares o_data_out after every fetch the bench issued
  logic fetch_seen = 1'b0;
  always @(posedge clk) fetch_seen <= cs && fetch && rst_b;

  always @(negedge clk) begin
    rd_t r;
    if (fetch_seen) begin
      if (expq.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected actual=%0h required=none", dout);
      end else begin
        r = expq.pop_front();
        chk($sformatf("rd_addr%0h", r.a), dout, r.e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] a;
    logic [7:0] d;
    logic       s;
    cfg = 4'($urandom_range(0, 15));
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_b = 1'b1;
    #1;
    chk("rst_pins", rf_pins, SAFE);
    chk("rst_busy", rf_busy, 1'b0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_outs", {led1, led0, pmod, pmod_dir, btn_irq}, 11'h0);
    bus_read(5'h00);
    bus_read(5'h07);

    // Table-driven sequence with full guard/settle timing
    bus_write(5'h06, 8'h02);
    bus_write(5'h07, 8'hA5);
    bus_write(5'h06, 8'h03);
    bus_write(5'h07, 8'h3C);
    #1 chk("unsel_tbl_no_busy", rf_busy, 1'b0);
    bus_write(5'h01, 8'h08);
    expect_seq("mode2", 8'hA5);
    m_busy = 1'b1;
    bus_read(5'h01);
    repeat (61) @(posedge clk);
    #1 chk("settle_end_busy", rf_busy, 1'b1);
    @(posedge clk); #1;
    chk("settle_done", rf_busy, 1'b0);
    m_busy = 1'b0;

    // Mode change during SETTLE re-enters the guard
    bus_write(5'h01, 8'h08);
    bus_write(5'h01, 8'h04);
    expect_seq("to_tbl1", SAFE);
    repeat (5) @(posedge clk);
    bus_write(5'h01, 8'h0C);
    expect_seq("settle_int", 8'h3C);
    wait_idle("tbl3");

    // Debug pattern path and return to table
    bus_write(5'h05, 8'hFF);
    repeat (2) @(posedge clk);
    #1 chk("rfdbg_no_effect", rf_busy, 1'b0);
    bus_write(5'h01, 8'h0D);
    expect_seq("dbg", 8'hFF);
    wait_idle("dbg");
    bus_read(5'h05);
    bus_write(5'h01, 8'h0C);
    expect_seq("undbg", 8'h3C);
    wait_idle("undbg");

    // Random register traffic that never disturbs the selected pattern
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = 5'($urandom_range(0, 15));
        if (a == 5'h01) a = 5'h04;
        d = 8'($urandom_range(0, 255));
        s = ($urandom_range(0, 7) != 0);
        if (a == 5'h07 && m_taddr == m_mode) d = m_tbl[m_taddr];
        bus_write(a, d, s);
      end else begin
        bus_read(5'($urandom_range(0, 31)));
      end
      chk("rand_busy", rf_busy, 1'b0);
    end
    chk("rand_outs", {led1, led0, pmod, pmod_dir}, {m_led1, m_led0, m_pval, m_pdir});

    // Button: short glitch rejected, long press accepted
    button = 1'b1;
    repeat (500) @(posedge clk);
    #1 button = 1'b0;
    repeat (50) @(posedge clk);
    bus_read(5'h02);
    bus_read(5'h08);
    button = 1'b1;
    repeat (1100) @(posedge clk);
    #1 button = 1'b0;
    chk("irq_pin", btn_irq, 1'b1);
    m_btn = 1'b1; m_irq = 1'b1;
    bus_read(5'h02);
    bus_read(5'h08);
    bus_read(5'h08);
    repeat (1100) @(posedge clk);
    m_btn = 1'b0;
    bus_read(5'h02);
    bus_read(5'h08);

    // Fetch and load together: read wins, no write
    bus_both(5'h02, {6'b0, ~m_led1, ~m_led0});
    #1 chk("both_leds", {led1, led0}, {m_led1, m_led0});

    // Reset in the middle of a guard
    bus_write(5'h01, 8'h08);
    repeat (5) @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("midrst_pins", rf_pins, SAFE);
    chk("midrst_busy", rf_busy, 1'b0);
    @(negedge clk) rst_b = 1'b1;
    model_reset();
    bus_read(5'h01);
    bus_read(5'h07);
    bus_read(5'h02);

    repeat (3) @(posedge clk);
    chk("rdq_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
